// File: rtl/clk_rate_monitor_if.sv
// Bundle between clk_rate_monitor and its consumer.
//   mon_clk       monitored clock, asynchronous to sys_clk (into the monitor)
//   rise_pulse    1-cycle strobe per synchronised mon_clk rise
//   fall_pulse    1-cycle strobe per synchronised mon_clk fall
//   period        last measured period in sys_clk cycles
//   period_valid  1-cycle strobe, period updated
//   locked        frequency within tolerance and stable
//   freq_err      1-cycle strobe, out-of-tolerance period while locked
//   clk_lost      level, no rise within the timeout window
//   high_time     last high-phase length (duty build only, else 0)
//   duty_err      1-cycle strobe, duty fault (duty build only, else 0)
// master: the monitor; slave: the consumer that drives mon_clk.
interface clk_rate_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             mon_clk;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             freq_err;
  logic             clk_lost;
  logic [CNT_W-1:0] high_time;
  logic             duty_err;

  modport master (
    input  mon_clk,
    output rise_pulse, fall_pulse, period, period_valid, locked,
           freq_err, clk_lost, high_time, duty_err
  );

  modport slave (
    output mon_clk,
    input  rise_pulse, fall_pulse, period, period_valid, locked,
           freq_err, clk_lost, high_time, duty_err
  );
endinterface

// File: rtl/clk_rate_monitor.sv
// Frequency/lock/loss checker for a slow clock sampled in the sys_clk domain.
// Synchronises mon_clk, emits edge strobes, measures the rise-to-rise period,
// declares lock after LOCK_COUNT consecutive in-tolerance periods and flags
// loss of clock after TIMEOUT cycles without a rise.
// Ports:
//   sys_clk  system clock, all logic on posedge
//   sys_rst  asynchronous, active-low reset
//   bus_if   clk_rate_monitor_if.master (mon_clk in, status/strobes out)
// Optional feature: define DUTY_CHECK_EN to enable high-phase measurement and
// duty_err; without it high_time and duty_err are tied to 0.
module clk_rate_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXP_PERIOD  = 4,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  clk_rate_monitor_if.master    bus_if
);

  typedef enum logic [1:0] {ST_IDLE, ST_MEAS, ST_LOCKED} state_e;

  localparam int unsigned      GW      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   EXP_X   = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_X   = (CNT_W+1)'(TOL);
  localparam logic [GW-1:0]    LOCK_N  = GW'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
  logic [GW-1:0]          good_cnt_q, good_cnt_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   freq_err_q, freq_err_d;
  logic                   clk_lost_q, clk_lost_d;

  logic                   s_cur, rise_c, fall_c, good_c;
  logic [CNT_W:0]         meas_c, diff_c;

  assign s_cur  = sync_q[SYNC_STAGES-1];
  assign rise_c = s_cur & ~s_prev_q;
  assign fall_c = ~s_cur & s_prev_q;

  // Measured period is one more than the count since the previous rise;
  // evaluated one bit wider so the tolerance compare cannot wrap.
  assign meas_c = {1'b0, per_cnt_q} + (CNT_W+1)'(1);
  assign diff_c = (meas_c >= EXP_X) ? (meas_c - EXP_X) : (EXP_X - meas_c);
  assign good_c = (diff_c <= TOL_X);

  // Synchroniser chain plus edge-history register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus_if.mon_clk};
      s_prev_q <= s_cur;
    end
  end

  // State and measurement registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q        <= ST_IDLE;
      per_cnt_q      <= '0;
      good_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      freq_err_q     <= 1'b0;
      clk_lost_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      per_cnt_q      <= per_cnt_d;
      good_cnt_q     <= good_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      freq_err_q     <= freq_err_d;
      clk_lost_q     <= clk_lost_d;
    end
  end

  // Next-state: a rise takes priority over the timeout in the same cycle.
  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    freq_err_d     = 1'b0;
    clk_lost_d     = clk_lost_q;
    per_cnt_d      = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);

    if (rise_c) begin
      per_cnt_d  = '0;
      clk_lost_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // No reference yet: this rise only starts the measurement.
          state_d    = ST_MEAS;
          good_cnt_d = '0;
        end
        ST_MEAS: begin
          period_d       = CNT_W'(meas_c);
          period_valid_d = 1'b1;
          if (good_c) begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_d == LOCK_N) state_d = ST_LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          period_d       = CNT_W'(meas_c);
          period_valid_d = 1'b1;
          if (!good_c) begin
            freq_err_d = 1'b1;
            good_cnt_d = '0;
            state_d    = ST_MEAS;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (per_cnt_q == TO_LAST) begin
      clk_lost_d = 1'b1;
      good_cnt_d = '0;
      state_d    = ST_IDLE;
    end
  end

  assign bus_if.rise_pulse   = rise_c;
  assign bus_if.fall_pulse   = fall_c;
  assign bus_if.period       = period_q;
  assign bus_if.period_valid = period_valid_q;
  assign bus_if.locked       = (state_q == ST_LOCKED);
  assign bus_if.freq_err     = freq_err_q;
  assign bus_if.clk_lost     = clk_lost_q;

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W+1:0] EXP2 = (CNT_W+2)'(EXP_PERIOD);
  localparam logic [CNT_W+1:0] TOL2 = (CNT_W+2)'(2 * TOL);

  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             duty_err_q, duty_err_d;
  logic [CNT_W:0]   hi_len_c;
  logic [CNT_W+1:0] hi2_c, ddiff_c;

  // High-phase counter and duty check, evaluated on each fall.
  always_comb begin
    hi_cnt_d    = hi_cnt_q;
    high_time_d = high_time_q;
    duty_err_d  = 1'b0;
    hi_len_c    = {1'b0, hi_cnt_q} + (CNT_W+1)'(1);
    hi2_c       = {hi_len_c, 1'b0};
    ddiff_c     = (hi2_c >= EXP2) ? (hi2_c - EXP2) : (EXP2 - hi2_c);
    if (rise_c) begin
      hi_cnt_d = '0;
    end else if (s_cur && (hi_cnt_q != CNT_MAX)) begin
      hi_cnt_d = hi_cnt_q + CNT_W'(1);
    end
    if (fall_c) begin
      high_time_d = CNT_W'(hi_len_c);
      duty_err_d  = (state_q == ST_LOCKED) && (ddiff_c > TOL2);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      hi_cnt_q    <= '0;
      high_time_q <= '0;
      duty_err_q  <= 1'b0;
    end else begin
      hi_cnt_q    <= hi_cnt_d;
      high_time_q <= high_time_d;
      duty_err_q  <= duty_err_d;
    end
  end

  assign bus_if.high_time = high_time_q;
  assign bus_if.duty_err  = duty_err_q;
`else
  assign bus_if.high_time = '0;
  assign bus_if.duty_err  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_rate_monitor.sv
// Directed bench for clk_rate_monitor: reset, lock, frequency error,
// loss of clock, async reset and the duty check (macro-dependent).
module tb_clk_rate_monitor;
  localparam int unsigned CNT_W = 8;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  clk_rate_monitor_if #(.CNT_W(CNT_W)) bus_if ();

  clk_rate_monitor #(
    .SYNC_STAGES(2), .CNT_W(CNT_W), .EXP_PERIOD(4), .TOL(0),
    .LOCK_COUNT(4), .TIMEOUT(64)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus_if (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_chk  = 0;
  int n_rise, n_fall, n_valid, n_ferr, n_duty, rise_idx, fall_idx;
  int duty_sum, waits;
  logic lock_at_valid;
  logic found;
  logic [22:0] outs;

  assign outs = {bus_if.rise_pulse, bus_if.fall_pulse, bus_if.period,
                 bus_if.period_valid, bus_if.locked, bus_if.freq_err,
                 bus_if.clk_lost, bus_if.high_time, bus_if.duty_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    n_rise = 0; n_fall = 0; n_valid = 0; n_ferr = 0; n_duty = 0;
    rise_idx = -1; fall_idx = -1; lock_at_valid = 1'b0;
  endtask

  // Drive mon_clk for one sys_clk cycle, then sample on the falling edge.
  task automatic step(input logic m, input int idx);
    bus_if.mon_clk = m;
    @(negedge sys_clk);
    if (bus_if.rise_pulse)   begin n_rise++; rise_idx = idx; end
    if (bus_if.fall_pulse)   begin n_fall++; fall_idx = idx; end
    if (bus_if.period_valid) begin n_valid++; lock_at_valid = bus_if.locked; end
    if (bus_if.freq_err)     n_ferr++;
    if (bus_if.duty_err)     n_duty++;
  endtask

  // One mon_clk period: hi cycles high then lo cycles low.
  task automatic run(input int hi, input int lo);
    clr();
    for (int k = 0; k < hi + lo; k++) step(k < hi, k);
  endtask

  // Step with mon_clk low until clk_lost appears, bounded.
  task automatic wait_lost();
    waits = 0; found = 1'b0;
    while (!found && waits < 200) begin
      step(1'b0, 0);
      waits++;
      if (bus_if.clk_lost) found = 1'b1;
    end
  endtask

  initial begin
    bus_if.mon_clk = 1'b0;
    clr();
    @(negedge sys_clk);

    // 1. Reset held with mon_clk toggling: everything stays 0.
    for (int i = 0; i < 6; i++) begin
      step(logic'(i % 2), i);
      chk("rst_hold_outs", 32'(outs), 32'd0);
    end
    sys_rst = 1'b1;
    step(1'b0, 0);
    step(1'b0, 0);
    chk("post_rst_outs", 32'(outs), 32'd0);
    run(2, 2);
    chk("first_rise_idx", 32'(rise_idx), 32'd1);
    chk("first_fall_idx", 32'(fall_idx), 32'd3);
    chk("first_rise_cnt", 32'(n_rise), 32'd1);
    chk("first_fall_cnt", 32'(n_fall), 32'd1);
    chk("first_no_valid", 32'(n_valid), 32'd0);

    // 2. Four good periods of 4 -> lock with the fourth strobe.
    for (int i = 0; i < 4; i++) begin
      run(2, 2);
      chk("lock_valid", 32'(n_valid), 32'd1);
      chk("lock_period", 32'(bus_if.period), 32'd4);
      chk("lock_with_valid", 32'(lock_at_valid), 32'(i == 3));
    end

    // 3. Stretched period -> freq_err, unlock, relock after 4.
    run(3, 3);
    chk("stretch_no_err", 32'(n_ferr), 32'd0);
    chk("stretch_still_lock", 32'(bus_if.locked), 32'd1);
    run(2, 2);
    chk("ferr_period", 32'(bus_if.period), 32'd6);
    chk("ferr_valid", 32'(n_valid), 32'd1);
    chk("ferr_pulse", 32'(n_ferr), 32'd1);
    chk("ferr_unlock", 32'(bus_if.locked), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run(2, 2);
      chk("relock", 32'(bus_if.locked), 32'(i == 3));
    end

    // 4. Stop mon_clk: lost 64 edges after the last rise strobe.
    // Rise seen at index 1 of the last run, two samples already taken.
    wait_lost();
    chk("lost_wait", 32'(waits), 32'd63);
    chk("lost_unlock", 32'(bus_if.locked), 32'd0);
    chk("lost_period_hold", 32'(bus_if.period), 32'd4);
    run(2, 2);
    chk("restart_clears_lost", 32'(bus_if.clk_lost), 32'd0);
    chk("restart_no_valid", 32'(n_valid), 32'd0);
    chk("restart_rise", 32'(n_rise), 32'd1);
    for (int i = 0; i < 4; i++) begin
      run(2, 2);
      chk("restart_lock", 32'(bus_if.locked), 32'(i == 3));
    end

    // 5. Asynchronous reset mid-period while locked.
    bus_if.mon_clk = 1'b1;
    @(negedge sys_clk);
    chk("pre_rst_locked", 32'(bus_if.locked), 32'd1);
    #2 sys_rst = 1'b0;
    #1 chk("async_rst_outs", 32'(outs), 32'd0);
    @(negedge sys_clk);
    step(1'b0, 0);
    step(1'b1, 0);
    chk("rst_mid_outs", 32'(outs), 32'd0);
    sys_rst = 1'b1;
    step(1'b0, 0);
    step(1'b0, 0);
    run(2, 2);
    chk("after_rst_no_valid", 32'(n_valid), 32'd0);
    chk("after_rst_rise", 32'(n_rise), 32'd1);
    chk("after_rst_unlock", 32'(bus_if.locked), 32'd0);

    // Timeout from reset with no rise at all.
    sys_rst = 1'b0;
    step(1'b0, 0);
    sys_rst = 1'b1;
    wait_lost();
    chk("rst_timeout_wait", 32'(waits), 32'd64);

    // 6. Lock at period 4, then switch to 1 high / 3 low.
    duty_sum = 0;
    run(2, 2);
    for (int i = 0; i < 4; i++) begin
      run(2, 2);
      duty_sum += n_duty;
    end
    chk("duty_pre_lock", 32'(bus_if.locked), 32'd1);
    chk("duty_pre_none", 32'(duty_sum), 32'd0);
`ifdef DUTY_CHECK_EN
    chk("duty_pre_high", 32'(bus_if.high_time), 32'd2);
`else
    chk("duty_pre_high", 32'(bus_if.high_time), 32'd0);
`endif
    run(1, 3);
    chk("duty_keep_lock", 32'(bus_if.locked), 32'd1);
    chk("duty_no_ferr", 32'(n_ferr), 32'd0);
    chk("duty_period", 32'(bus_if.period), 32'd4);
    chk("duty_valid", 32'(n_valid), 32'd1);
`ifdef DUTY_CHECK_EN
    chk("duty_err_pulse", 32'(n_duty), 32'd1);
    chk("duty_high_time", 32'(bus_if.high_time), 32'd1);
`else
    chk("duty_err_pulse", 32'(n_duty), 32'd0);
    chk("duty_high_time", 32'(bus_if.high_time), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
